// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: synchronizes and filters scl/sda, detects START/rSTART/STOP and deserializes bytes into a valid/ready buffer.
// Optional scl-low timeout enabled by defining I2C_MON_TIMEOUT_EN.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 3,
  parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [7:0] byte_data,
  output logic       byte_ack,
  output logic       byte_first,
  output logic       start_det,
  output logic       rstart_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic       timeout
);
  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  typedef enum logic [1:0] {IDLE, DATA, ACK} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] s [2];
  logic [CW-1:0] c [2];
  logic [1:0] f, p, pin;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic first, start_c, stop_c, rise, commit, to_hit;
  assign pin = {sda_in, scl_in};
  // index 0 = scl, index 1 = sda
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        s[k] <= '1;
        c[k] <= '0;
      end
      f <= 2'b11;
      p <= 2'b11;
    end else begin
      p <= f;
      for (int k = 0; k < 2; k++) begin
        s[k] <= {s[k][SYNC_STAGES-2:0], pin[k]};
        if (s[k][SYNC_STAGES-1] == f[k]) c[k] <= '0;
        else if (c[k] == CW'(FILT_LEN - 1)) begin
          f[k] <= ~f[k];
          c[k] <= '0;
        end else c[k] <= c[k] + 1'b1;
      end
    end
  // requiring scl high in both samples also excludes simultaneous scl/sda changes
  assign start_c = p[0] & f[0] & p[1] & ~f[1];
  assign stop_c = p[0] & f[0] & ~p[1] & f[1];
  assign rise = ~p[0] & f[0];
  assign commit = (state == ACK) && rise;
`ifdef I2C_MON_TIMEOUT_EN
  logic [15:0] tcnt;
  assign to_hit = bus_busy && !f[0] && (tcnt == TIMEOUT_CYC - 16'd1);
  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt <= '0;
    else tcnt <= (!bus_busy || f[0] || to_hit) ? '0 : tcnt + 16'd1;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bitcnt <= '0;
      shreg <= '0;
      first <= 1'b0;
      bus_busy <= 1'b0;
      start_det <= 1'b0;
      rstart_det <= 1'b0;
      stop_det <= 1'b0;
      timeout <= 1'b0;
    end else begin
      start_det <= start_c;
      rstart_det <= start_c && (state != IDLE);
      stop_det <= stop_c;
      timeout <= to_hit;
      if (stop_c || to_hit) begin
        state <= IDLE;
        bitcnt <= '0;
        bus_busy <= 1'b0;
      end else if (start_c) begin
        state <= DATA;
        bitcnt <= '0;
        first <= 1'b1;
        bus_busy <= 1'b1;
      end else if (rise && state == DATA) begin
        shreg <= {shreg[6:0], f[1]};
        bitcnt <= bitcnt + 3'd1;
        state <= (bitcnt == 3'd7) ? ACK : DATA;
      end else if (rise && state == ACK) begin
        first <= 1'b0;
        bitcnt <= '0;
        state <= DATA;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      byte_valid <= 1'b0;
      byte_data <= '0;
      byte_ack <= 1'b0;
      byte_first <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (commit && byte_valid && !byte_ready) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
      if (commit && (!byte_valid || byte_ready)) begin
        byte_valid <= 1'b1;
        byte_data <= shreg;
        byte_ack <= ~f[1];
        byte_first <= first;
      end else if (byte_ready) byte_valid <= 1'b0;
    end
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb_i2c_bus_monitor: directed and random I2C transactions checked against a transaction-level byte/event model.
module tb_i2c_bus_monitor;
  localparam int Q = 10;
  logic clk = 0, rst = 1, scl_in = 1, sda_in = 1, byte_ready = 1, overrun_clr = 0;
  logic byte_valid, byte_ack, byte_first, start_det, rstart_det, stop_det, bus_busy, overrun, timeout;
  logic [7:0] byte_data;
  int errors = 0, checks = 0;
  int n_st = 0, n_rs = 0, n_sp = 0, n_to = 0, e_st = 0, e_rs = 0, e_sp = 0, e_to = 0;
  logic [9:0] q [$];
  bit m_busy = 0, m_first = 0, e_ovr = 0;

  i2c_bus_monitor #(.SYNC_STAGES(2), .FILT_LEN(3), .TIMEOUT_CYC(16'd100)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_ack(byte_ack), .byte_first(byte_first), .start_det(start_det),
    .rstart_det(rstart_det), .stop_det(stop_det), .bus_busy(bus_busy),
    .overrun(overrun), .overrun_clr(overrun_clr), .timeout(timeout));

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    n_st += int'(start_det);
    n_rs += int'(rstart_det);
    n_sp += int'(stop_det);
    n_to += int'(timeout);
    if (byte_valid && byte_ready) begin
      logic [9:0] e;
      if (q.size() > 0) e = q.pop_front();
      else e = 10'bx;
      chk("byte", {byte_data, byte_ack, byte_first}, e);
    end
  end

  task automatic wq;
    repeat (Q) @(posedge clk);
    #1;
  endtask
  task automatic bus_start;
    e_st++;
    if (m_busy) e_rs++;
    m_busy = 1;
    m_first = 1;
    sda_in = 1; wq; scl_in = 1; wq; sda_in = 0; wq; scl_in = 0; wq;
  endtask
  task automatic bus_stop;
    e_sp++;
    m_busy = 0;
    sda_in = 0; wq; scl_in = 1; wq; sda_in = 1; wq;
  endtask
  task automatic bus_bit(input bit b);
    sda_in = b; wq; scl_in = 1; wq; wq; scl_in = 0; wq;
  endtask
  task automatic send(input logic [7:0] d, input bit ack);
    for (int i = 7; i >= 0; i--) bus_bit(d[i]);
    if (!byte_ready && q.size() > 0) e_ovr = 1;
    else q.push_back({d, ack, m_first});
    m_first = 0;
    bus_bit(!ack);
  endtask
  task automatic counts(string tag);
    chk({tag, "_starts"}, n_st, e_st);
    chk({tag, "_rstarts"}, n_rs, e_rs);
    chk({tag, "_stops"}, n_sp, e_sp);
    chk({tag, "_timeouts"}, n_to, e_to);
    chk({tag, "_qempty"}, q.size(), 0);
    chk({tag, "_busy"}, bus_busy, m_busy);
  endtask
  task automatic glitch(input int n);
    @(posedge clk); #1 sda_in = 0;
    repeat (n) @(posedge clk);
    #1 sda_in = 1;
    wq;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {byte_valid, byte_data, byte_ack, byte_first, start_det, rstart_det,
                          stop_det, bus_busy, overrun, timeout}, 0);
    rst = 0;
    wq;
    bus_start; send(8'hA4, 1); bus_stop; wq;
    counts("single");
    bus_start; send(8'h50, 1); send(8'h3C, 0); bus_start; send(8'h51, 1); bus_stop; wq;
    counts("rstart");
    byte_ready = 0;
    bus_start; send(8'h11, 1); send(8'h22, 1); bus_stop; wq;
    chk("hold_valid", byte_valid, 1);
    chk("hold_data", byte_data, q[0][9:2]);
    chk("overrun_set", overrun, e_ovr);
    overrun_clr = 1; @(posedge clk); #1 overrun_clr = 0; e_ovr = 0;
    chk("overrun_clr", overrun, e_ovr);
    byte_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("drained_valid", byte_valid, 0);
    counts("overrun");
    glitch(2);
    counts("glitch_short");
    glitch(3);
    e_st++; e_sp++;
    counts("glitch_long");
    bus_start;
    for (int i = 0; i < 4; i++) bus_bit(1'($urandom));
    bus_stop; wq;
    chk("partial_valid", byte_valid, 0);
    counts("partial");
    bus_start; send(8'hFF, 1); bus_stop; wq;
    counts("after_partial");
    repeat (20) begin
      bus_start;
      repeat ($urandom_range(1, 3)) send(8'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        bus_start;
        repeat ($urandom_range(1, 2)) send(8'($urandom), 1'($urandom));
      end
      bus_stop; wq;
    end
    counts("random");
`ifdef I2C_MON_TIMEOUT_EN
    bus_start;
    for (int i = 0; i < 3; i++) bus_bit(1'($urandom));
    repeat (150) @(posedge clk);
    #1;
    e_to++;
    m_busy = 0;
    counts("timeout");
    sda_in = 0; wq; scl_in = 1; wq; sda_in = 1; wq;
    e_sp++;
    counts("timeout_stop");
`endif
    byte_ready = 0;
    bus_start; send(8'h5A, 1);
    for (int i = 0; i < 3; i++) bus_bit(1'($urandom));
    chk("pre_reset_valid", byte_valid, 1);
    #2 rst = 1;
    #1;
    chk("midbyte_reset", {byte_valid, byte_data, byte_ack, byte_first, start_det, rstart_det,
                          stop_det, bus_busy, overrun, timeout}, 0);
    q.delete();
    m_busy = 0;
    scl_in = 1; sda_in = 1;
    repeat (10) @(posedge clk);
    #1 rst = 0;
    byte_ready = 1;
    wq;
    bus_start; send(8'hC3, 0); bus_stop; wq;
    counts("post_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
